// File: rtl/adder_tree_pkg.sv
// Shared types and constants for the adder-tree scheduler.
package adder_tree_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NI_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    // Counter/index width that holds values 0..limit-1, never narrower than 1 bit.
    function automatic int unsigned clog2(input int unsigned limit);
        return (limit < 2) ? 32'd1 : 32'($clog2(limit));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NR    = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NR-1:0]    req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [NR-1:0]    grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    localparam int unsigned CW = IDX_W + 1;

    logic [CW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            // One extra bit so non-power-of-two NR wraps correctly.
            cand = {1'b0, rr_ptr_i} + CW'(k);
            if (cand >= CW'(NR)) begin
                cand = cand - CW'(NR);
            end
            for (int unsigned i = 0; i < NR; i++) begin
                if (!valid_o && req_i[i] && (cand == CW'(i))) begin
                    valid_o    = 1'b1;
                    idx_o      = IDX_W'(i);
                    grant_o[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adder_tree_sched.sv
// Round-robin scheduler sharing one floating-point adder tree among NR requesters,
// with a watchdog that aborts a transaction if the tree never finishes or never releases.
module adder_tree_sched
    import adder_tree_pkg::*;
#(
    parameter int unsigned NR      = 4,
    parameter int unsigned NI      = NI_DEF,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NR-1:0]            req,
    input  logic [NR*NI*WORD_W-1:0]  req_data,
    output logic [NR-1:0]            grant,
    output logic [NR-1:0]            done,
    output logic [WORD_W-1:0]        result,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     tree_start,
    output logic [NI*WORD_W-1:0]     tree_inputs,
    input  logic [WORD_W-1:0]        tree_sum,
    input  logic                     tree_finish
);

    localparam int unsigned VEC_W = NI * WORD_W;
    localparam int unsigned IDX_W = clog2(NR);
    localparam int unsigned CNT_W = clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    sched_state_t       state_q,  state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q,  owner_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [NR-1:0]      grant_q,  grant_d;
    logic [NR-1:0]      done_q,   done_d;
    logic [WORD_W-1:0]  result_q, result_d;
    logic               busy_q,   busy_d;
    logic               terr_q,   terr_d;
    logic               start_q,  start_d;
    logic [VEC_W-1:0]   inputs_q, inputs_d;

    logic [NR-1:0]      arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [VEC_W-1:0]   sel_vec;

    rr_arbiter #(
        .NR    (NR),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (arb_grant),
        .idx_o    (arb_idx),
        .valid_o  (arb_valid)
    );

    // Operand slice of the requester the arbiter is currently picking.
    always_comb begin
        sel_vec = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (arb_grant[i]) begin
                sel_vec = req_data[i*VEC_W +: VEC_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        grant_d  = '0;
        done_d   = '0;
        result_d = result_q;
        terr_d   = terr_q;
        start_d  = start_q;
        inputs_d = inputs_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    inputs_d = sel_vec;
                    owner_d  = arb_idx;
                    grant_d  = arb_grant;
                    start_d  = 1'b1;
                    cnt_d    = '0;
                    rr_ptr_d = (arb_idx == IDX_W'(NR - 1)) ? '0 : arb_idx + IDX_W'(1);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tree_finish) begin
                    result_d = tree_sum;
                    done_d   = NR'(1) << owner_q;
                    start_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_DRAIN;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d  = 1'b1;
                    start_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                // Tree must drop finish before the next start, or it would look stale.
                if (!tree_finish) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
            start_q  <= 1'b0;
            inputs_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            terr_q   <= terr_d;
            start_q  <= start_d;
            inputs_q <= inputs_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign result      = result_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    assign tree_start  = start_q;
    assign tree_inputs = inputs_q;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Bench for adder_tree_sched: behavioural adder tree, round-robin reference model
// with a result scoreboard, a transaction table and hand-written corner sequences.
module tb_adder_tree_sched;

    localparam int NR      = 4;
    localparam int NI      = 8;
    localparam int VEC     = NI * 32;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [NR-1:0] owner;
        logic [31:0]   sum;
    } exp_t;

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] exp_grant;
        int            seed;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*VEC-1:0] req_data = '0;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic [31:0]       result;
    logic              busy;
    logic              timeout_err;
    logic              tree_start;
    logic [VEC-1:0]    tree_inputs;
    logic [31:0]       tree_sum = '0;
    logic              tree_finish = 1'b0;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   m_ptr = 0;
    bit   terr_seen = 1'b0;
    logic [31:0] last_result = '0;

    int tm_lat = 5;
    int tm_hold_len = 1;
    bit tm_hang = 1'b0;
    int tm_cnt = 0;
    int tm_hold = 0;
    bit tm_fired = 1'b0;

    always #5 clk = ~clk;

    adder_tree_sched #(
        .NR      (NR),
        .NI      (NI),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .done        (done),
        .result      (result),
        .busy        (busy),
        .timeout_err (timeout_err),
        .tree_start  (tree_start),
        .tree_inputs (tree_inputs),
        .tree_sum    (tree_sum),
        .tree_finish (tree_finish)
    );

    task automatic chk(input string name, input logic [VEC-1:0] act, input logic [VEC-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtof(real r);
        logic [63:0] b;
        int e;
        if (r == 0.0) return 32'd0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic real ftor(logic [31:0] f);
        int e;
        if (f[30:0] == 31'd0) return 0.0;
        e = int'(f[30:23]) - 127 + 1023;
        return $bitstoreal({f[31], e[10:0], f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] vsum(logic [VEC-1:0] v);
        real s;
        s = 0.0;
        for (int k = 0; k < NI; k++) s = s + ftor(v[k*32 +: 32]);
        return rtof(s);
    endfunction

    function automatic int model_pick(logic [NR-1:0] r, int ptr);
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (ptr + k) % NR;
            if (((r >> j) & 4'b0001) != 4'b0000) return j;
        end
        return -1;
    endfunction

    function automatic int oh2idx(logic [NR-1:0] oh);
        for (int i = 0; i < NR; i++) if (oh == (4'b0001 << i)) return i;
        return 0;
    endfunction

    task automatic fill_data(input int seed);
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < NI; k++)
                req_data[(i*NI + k)*32 +: 32] = rtof(real'(seed + i*NI + k + 1));
    endtask

    task automatic wait_grant(output logic [NR-1:0] g);
        g = '0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (grant != '0) begin
                g = grant;
                return;
            end
        end
        n_chk++;
        n_err++;
        $display("FAIL grant_wait: no grant within 200 cycles");
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (!busy && sb.size() == 0) return;
        end
        n_chk++;
        n_err++;
        $display("FAIL idle_wait: busy=%0b pending=%0d after 200 cycles", busy, sb.size());
    endtask

    // Behavioural tree: finish tm_lat cycles after start, held tm_hold_len cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            tree_finish = 1'b0;
            tree_sum    = '0;
            tm_cnt      = 0;
            tm_hold     = 0;
            tm_fired    = 1'b0;
        end else if (tree_finish) begin
            tm_hold--;
            if (tm_hold <= 0) tree_finish = 1'b0;
        end else if (tree_start && !tm_fired) begin
            tm_cnt++;
            if (tm_cnt >= tm_lat && !tm_hang) begin
                tree_sum    = vsum(tree_inputs);
                tree_finish = 1'b1;
                tm_fired    = 1'b1;
                tm_hold     = tm_hold_len;
            end
        end else if (!tree_start) begin
            tm_cnt   = 0;
            tm_fired = 1'b0;
        end
    end

    // Reference arbiter and scoreboard.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            sb.delete();
            m_ptr       = 0;
            terr_seen   = 1'b0;
            last_result = '0;
        end else begin
            if (grant != '0) begin
                int   pick;
                exp_t e;
                pick = model_pick(req, m_ptr);
                chk("mon_grant", VEC'(grant), VEC'(4'b0001 << pick));
                if (pick >= 0) begin
                    chk("mon_inputs", tree_inputs, req_data[pick*VEC +: VEC]);
                    e.owner = 4'b0001 << pick;
                    e.sum   = vsum(req_data[pick*VEC +: VEC]);
                    sb.push_back(e);
                    m_ptr = (pick + 1) % NR;
                end
            end
            if (done != '0) begin
                chk("sb_nonempty", VEC'(sb.size() != 0), VEC'(1));
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_done", VEC'(done), VEC'(e.owner));
                    chk("sb_result", VEC'(result), VEC'(e.sum));
                    last_result = e.sum;
                end
            end
            if (timeout_err && !terr_seen) begin
                terr_seen = 1'b1;
                if (sb.size() != 0) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[8];
        logic [NR-1:0] g;
        logic [VEC-1:0] snap;
        int            cyc;
        int            done_cnt;
        bit            drain_ok;

        tbl[0] = '{4'b0001, 4'b0001, 0};
        tbl[1] = '{4'b0010, 4'b0010, 40};
        tbl[2] = '{4'b1010, 4'b1000, 80};
        tbl[3] = '{4'b1010, 4'b0010, 120};
        tbl[4] = '{4'b0101, 4'b0100, 160};
        tbl[5] = '{4'b0011, 4'b0001, 200};
        tbl[6] = '{4'b1001, 4'b1000, 240};
        tbl[7] = '{4'b1111, 4'b0001, 280};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", VEC'(grant), '0);
        chk("rst_done", VEC'(done), '0);
        chk("rst_busy", VEC'(busy), '0);
        chk("rst_terr", VEC'(timeout_err), '0);
        chk("rst_start", VEC'(tree_start), '0);
        chk("rst_result", VEC'(result), '0);
        chk("rst_inputs", tree_inputs, '0);
        @(negedge clk) rst_n = 1'b1;

        // Contention: all requests held, round-robin from 0.
        fill_data(500);
        @(negedge clk) req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_grant(g);
            chk($sformatf("cont_grant%0d", t), VEC'(g), VEC'(4'b0001 << (t % NR)));
        end
        @(negedge clk) req = '0;
        wait_idle();

        // Table of single transactions, with operand-stability check after grant.
        for (int i = 0; i < 8; i++) begin
            fill_data(tbl[i].seed);
            snap = req_data[oh2idx(tbl[i].exp_grant)*VEC +: VEC];
            @(negedge clk) req = tbl[i].req;
            wait_grant(g);
            chk($sformatf("tbl%0d_grant", i), VEC'(g), VEC'(tbl[i].exp_grant));
            chk($sformatf("tbl%0d_start", i), VEC'(tree_start), VEC'(1));
            @(negedge clk);
            req      = '0;
            req_data = ~req_data;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_stable", i), tree_inputs, snap);
            wait_idle();
            if (i == 0) chk("single_result", VEC'(result), VEC'(32'h42100000));
        end

        // Hung tree: watchdog abort after TIMEOUT cycles, next request still served.
        tm_hang = 1'b1;
        @(negedge clk) req = 4'b0010;
        wait_grant(g);
        chk("to_grant", VEC'(g), VEC'(4'b0010));
        @(negedge clk) req = '0;
        cyc      = 0;
        done_cnt = 0;
        for (int c = 1; c <= TIMEOUT + 8; c++) begin
            @(posedge clk); #1;
            if (done != '0) done_cnt++;
            if (timeout_err) begin
                cyc = c;
                break;
            end
        end
        chk("to_cycles", VEC'(cyc), VEC'(TIMEOUT));
        chk("to_start", VEC'(tree_start), '0);
        chk("to_busy", VEC'(busy), '0);
        chk("to_no_done", VEC'(done_cnt), '0);
        chk("to_result_held", VEC'(result), VEC'(last_result));
        tm_hang = 1'b0;
        fill_data(600);
        @(negedge clk) req = 4'b0001;
        wait_grant(g);
        chk("to_next_grant", VEC'(g), VEC'(4'b0001));
        @(negedge clk) req = '0;
        wait_idle();
        chk("to_sticky", VEC'(timeout_err), VEC'(1));

        // Asynchronous reset in the middle of WAIT.
        tm_lat = 20;
        @(negedge clk) req = 4'b0100;
        wait_grant(g);
        chk("mr_grant", VEC'(g), VEC'(4'b0100));
        @(negedge clk) req = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_grant0", VEC'(grant), '0);
        chk("mr_done0", VEC'(done), '0);
        chk("mr_busy0", VEC'(busy), '0);
        chk("mr_terr0", VEC'(timeout_err), '0);
        chk("mr_start0", VEC'(tree_start), '0);
        chk("mr_result0", VEC'(result), '0);
        chk("mr_inputs0", tree_inputs, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tm_lat = 5;
        @(negedge clk) req = 4'b1111;
        wait_grant(g);
        chk("mr_rr_restart", VEC'(g), VEC'(4'b0001));
        @(negedge clk) req = '0;
        wait_idle();

        // Long finish: one done, stay in DRAIN, pending request granted after release.
        tm_hold_len = 10;
        @(negedge clk) req = 4'b0010;
        wait_grant(g);
        chk("lf_grant", VEC'(g), VEC'(4'b0010));
        @(negedge clk) req = 4'b0100;
        done_cnt = 0;
        drain_ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (done != '0) done_cnt++;
            if (tree_finish) break;
        end
        tm_hold_len = 1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (done != '0) done_cnt++;
            if (!tree_finish) break;
            if (!busy || grant != '0) drain_ok = 1'b0;
        end
        chk("lf_one_done", VEC'(done_cnt), VEC'(1));
        chk("lf_drain_held", VEC'(drain_ok), VEC'(1));
        chk("lf_exit_idle", VEC'(busy), '0);
        chk("lf_exit_nogrant", VEC'(grant), '0);
        @(posedge clk); #1;
        chk("lf_regrant", VEC'(grant), VEC'(4'b0100));
        @(negedge clk) req = '0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
